comb_truth_scanner: RTL

Exhaustive truth-table scanner for the 3-input combinational stage (A, B, C → Y). It drives all eight input vectors into the combinational stage in order, samples Y after a programmable settle time, and builds an 8-bit captured truth table. It then compares the table against an expected mask and reports pass/fail. It sits on both sides of the combinational block: it feeds A/B/C and consumes Y.

---
 rtl/comb_truth_scanner_if.sv | 41 ++++
 rtl/comb_truth_scanner.sv | 84 ++++++++
 2 files changed

// File: rtl/comb_truth_scanner_if.sv
// rtl/comb_truth_scanner_if.sv - control, status and stage-drive signals of the truth-table scanner
interface comb_truth_scanner_if;
    logic       start;
    logic       Y;
    logic       A;
    logic       B;
    logic       C;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] capture;
    logic [7:0] mismatch;

    // host side: requests scans, closes the loop through the combinational stage
    modport master (
        output start,
        output Y,
        input  A,
        input  B,
        input  C,
        input  busy,
        input  done,
        input  pass,
        input  capture,
        input  mismatch
    );

    // scanner side
    modport slave (
        input  start,
        input  Y,
        output A,
        output B,
        output C,
        output busy,
        output done,
        output pass,
        output capture,
        output mismatch
    );
endinterface

// File: rtl/comb_truth_scanner.sv
// rtl/comb_truth_scanner.sv - exhaustive 3-input truth-table scanner with expected-mask compare
module comb_truth_scanner #(
    parameter logic [7:0] EXPECTED = 8'hB4,
    parameter int         SETTLE   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    comb_truth_scanner_if.slave  bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    // last settle count before the sample cycle; SETTLE is 1..15 so this fits 4 bits
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    logic [1:0] state;
    logic [2:0] idx;
    logic [3:0] cnt;
    logic [2:0] abc;
    logic       pass_q;
    logic [7:0] capture_q;
    logic [7:0] mismatch_q;

    // scan sequencer: drive vector, wait SETTLE cycles, sample Y, advance; compare after vector 7
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            idx        <= 3'd0;
            cnt        <= 4'd0;
            abc        <= 3'd0;
            pass_q     <= 1'b0;
            capture_q  <= 8'h00;
            mismatch_q <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    abc <= 3'd0;
                    if (bus.start) begin
                        idx       <= 3'd0;
                        cnt       <= 4'd0;
                        capture_q <= 8'h00;
                        state     <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    abc <= idx;
                    if (cnt == SETTLE_LAST) begin
                        cnt   <= 4'd0;
                        state <= S_SAMPLE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_SAMPLE: begin
                    capture_q[idx] <= bus.Y;
                    if (idx == 3'd7) begin
                        // bit 7 is being captured this very edge, so splice Y in directly
                        pass_q     <= ({bus.Y, capture_q[6:0]} == EXPECTED);
                        mismatch_q <= {bus.Y, capture_q[6:0]} ^ EXPECTED;
                        state      <= S_DONE;
                    end else begin
                        idx   <= idx + 3'd1;
                        state <= S_SETTLE;
                    end
                end
                default: begin
                    abc   <= 3'd0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.A        = abc[2];
    assign bus.B        = abc[1];
    assign bus.C        = abc[0];
    assign bus.busy     = (state != S_IDLE);
    assign bus.done     = (state == S_DONE);
    assign bus.pass     = pass_q;
    assign bus.capture  = capture_q;
    assign bus.mismatch = mismatch_q;
endmodule
